// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU control path.
// States, instruction classes, ALU codes and branch conditions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] CL_LOAD  = 2'b00;
  localparam logic [1:0] CL_STORE = 2'b01;
  localparam logic [1:0] CL_IMM   = 2'b10;
  localparam logic [1:0] CL_ARITH = 2'b11;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_OUT  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] SUB_LI  = 3'b000;
  localparam logic [2:0] SUB_B   = 3'b100;
  localparam logic [2:0] SUB_BCC = 3'b111;

  localparam logic [2:0] CC_EQ = 3'b000;
  localparam logic [2:0] CC_LT = 3'b001;
  localparam logic [2:0] CC_LE = 3'b010;
  localparam logic [2:0] CC_NE = 3'b011;

endpackage

// File: rtl/cpu_branch_eval.sv
// Conditional-branch resolver over the registered {V,C,Z,S} flags.
// Unlisted condition codes resolve to not-taken.
module cpu_branch_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic v, z, s;
  logic unused_carry;

  assign v = flags[3];
  assign z = flags[1];
  assign s = flags[0];
  assign unused_carry = flags[2];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CC_EQ:   taken = z;
      CC_LT:   taken = s ^ v;
      CC_LE:   taken = z | (s ^ v);
      CC_NE:   taken = ~z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase sequencer: fetch, operand read, ALU, memory, writeback.
// All strobes are decoded from the state register, the IR and the flags.
module cpu_phase_sequencer
  import cpu_pkg::*;
#(
  parameter int               OP_W    = 4,
  parameter logic [OP_W-1:0]  ALU_ADD = OP_ADD
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            run,
  input  logic [15:0]     ir,
  input  logic [3:0]      flags,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            ab_load,
  output logic [OP_W-1:0] alu_op,
  output logic            alu_src_imm,
  output logic            dr_load,
  output logic            flags_load,
  output logic            mdr_load,
  output logic            reg_we,
  output logic            reg_wsel,
  output logic            out_valid,
  output logic            halted
);

  state_t    state, state_nxt;
  state_t    resume;
  logic      taken;
  logic      unused_bits;
  logic [1:0] cls;
  logic [2:0] sub;
  logic [OP_W-1:0] op;

  assign cls = ir[15:14];
  assign sub = ir[13:11];
  assign op  = ir[7:4];
  assign unused_bits = ^ir[3:0];

  // Instruction boundary: a dropped run parks the sequencer instead of fetching.
  assign resume = run ? S_FETCH : S_IDLE;

  cpu_branch_eval u_branch_eval (
    .cond  (ir[10:8]),
    .flags (flags),
    .taken (taken)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ab_load      = 1'b0;
    alu_op       = ALU_ADD;
    alu_src_imm  = 1'b0;
    dr_load      = 1'b0;
    flags_load   = 1'b0;
    mdr_load     = 1'b0;
    reg_we       = 1'b0;
    reg_wsel     = 1'b0;
    out_valid    = 1'b0;
    halted       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_load     = 1'b1;
        alu_src_imm = (cls != CL_ARITH);
        state_nxt   = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          (cls == CL_ARITH): begin
            alu_op     = op;
            dr_load    = 1'b1;
            flags_load = (op != OP_HALT);
            if (op == OP_HALT) begin
              state_nxt = S_HALT;
            end else if (op == OP_CMP) begin
              state_nxt = resume;
            end else if (op == OP_OUT) begin
              out_valid = 1'b1;
              state_nxt = resume;
            end else begin
              state_nxt = S_WB;
            end
          end
          (cls == CL_LOAD),
          (cls == CL_STORE): begin
            dr_load   = 1'b1;
            state_nxt = S_MEM;
          end
          default: begin
            if (sub == SUB_LI) begin
              dr_load   = 1'b1;
              state_nxt = S_WB;
            end else begin
              pc_load   = (sub == SUB_B) |
                          ((sub == SUB_BCC) & taken);
              state_nxt = resume;
            end
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == CL_STORE);
        if (mem_ready) begin
          if (cls == CL_STORE) begin
            state_nxt = resume;
          end else begin
            mdr_load  = 1'b1;
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        reg_wsel  = (cls == CL_LOAD);
        state_nxt = resume;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer.
// Walks each instruction class phase by phase against hand-derived strobes.
module tb_cpu_phase_sequencer;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic [15:0] ir;
  logic [3:0]  flags;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel;
  logic        ir_load, pc_inc, pc_load, ab_load;
  logic [3:0]  alu_op;
  logic        alu_src_imm, dr_load, flags_load, mdr_load;
  logic        reg_we, reg_wsel, out_valid, halted;
  logic [18:0] outs;

  int checks = 0;
  int errors = 0;

  cpu_phase_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .ir           (ir),
    .flags        (flags),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .ab_load      (ab_load),
    .alu_op       (alu_op),
    .alu_src_imm  (alu_src_imm),
    .dr_load      (dr_load),
    .flags_load   (flags_load),
    .mdr_load     (mdr_load),
    .reg_we       (reg_we),
    .reg_wsel     (reg_wsel),
    .out_valid    (out_valid),
    .halted       (halted)
  );

  assign outs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc,
                 pc_load, ab_load, alu_op, alu_src_imm, dr_load,
                 flags_load, mdr_load, reg_we, reg_wsel, out_valid,
                 halted};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    run       = 1'b0;
    ir        = 16'h0000;
    flags     = 4'b0000;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_outs", 32'(outs), 32'h0);
    reset_n = 1'b1;

    // idle with run low
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", 32'(outs), 32'h0);
    end

    // ADD r1,r0: FETCH, DECODE, EXEC, WB
    ir = 16'hC800; mem_ready = 1'b1; run = 1'b1;
    tick();
    chk("add_f_req", 32'(mem_req), 1);
    chk("add_f_irl", 32'({ir_load, pc_inc, mem_addr_sel}), 32'b110);
    tick();
    chk("add_d_ab", 32'({ab_load, alu_src_imm}), 32'b10);
    tick();
    chk("add_e", 32'({dr_load, flags_load, reg_we}), 32'b110);
    chk("add_e_op", 32'(alu_op), 0);
    tick();
    chk("add_wb", 32'({reg_we, reg_wsel, dr_load}), 32'b100);
    run = 1'b0;
    tick();
    chk("add_idle", 32'(outs), 32'h0);

    // LD with memory wait states
    ir = 16'h0805; run = 1'b1;
    tick();
    chk("ld_f", 32'(ir_load), 1);
    tick();
    chk("ld_d_imm", 32'(alu_src_imm), 1);
    tick();
    chk("ld_e", 32'({dr_load, flags_load, alu_op}), 32'b10_0000);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_wait", 32'({mem_req, mem_addr_sel, mem_we, mdr_load}),
          32'b1100);
    end
    mem_ready = 1'b1;
    #1;
    chk("ld_ready", 32'({mem_req, mdr_load}), 32'b11);
    tick();
    chk("ld_wb", 32'({reg_we, reg_wsel, mdr_load}), 32'b110);

    // BE -2 taken, then not taken
    ir = 16'hB8FE; flags = 4'b0010;
    tick();
    tick();
    chk("be_d_imm", 32'(alu_src_imm), 1);
    tick();
    chk("be_t", 32'({pc_load, dr_load}), 32'b10);
    tick();
    chk("be_t_ret", 32'({mem_req, pc_load}), 32'b10);
    flags = 4'b0000;
    tick();
    tick();
    chk("be_nt", 32'(pc_load), 0);
    tick();
    chk("be_nt_ret", 32'(mem_req), 1);

    // BLT with S^V set via V only
    ir = 16'hB9FE; flags = 4'b1000;
    tick();
    tick();
    chk("blt_t", 32'(pc_load), 1);
    run = 1'b0;
    tick();
    chk("blt_idle", 32'(outs), 32'h0);

    // OUT pulses out_valid and skips WB
    ir = 16'hC0D0; run = 1'b1;
    tick();
    tick();
    tick();
    chk("out_e", 32'({out_valid, dr_load, flags_load}), 32'b111);
    tick();
    chk("out_ret", 32'({mem_req, reg_we, out_valid}), 32'b100);

    // HALT absorbs until reset
    ir = 16'hC0F0;
    tick();
    tick();
    chk("halt_e", 32'({dr_load, flags_load, halted}), 32'b100);
    tick();
    chk("halt_on", 32'(halted), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", 32'({halted, mem_req, ir_load}), 32'b100);
    end
    reset_n = 1'b0;
    #1;
    chk("halt_rst", 32'(halted), 0);
    run = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("halt_idle", 32'(outs), 32'h0);

    // Store interrupted by reset during MEM
    ir = 16'h4803; run = 1'b1; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("st_e", 32'(dr_load), 1);
    mem_ready = 1'b0;
    tick();
    chk("st_mem", 32'({mem_req, mem_we, mem_addr_sel}), 32'b111);
    #2;
    reset_n = 1'b0;
    #1;
    chk("st_async", 32'({mem_req, mem_we}), 32'b00);
    run = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("st_idle", 32'(outs), 32'h0);
    run = 1'b1;
    tick();
    chk("st_refetch", 32'({mem_req, mem_we, mem_addr_sel}), 32'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
